// File: rtl/cpu_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification helpers
// for the 8-bit core's control path and execute stage.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_MEMRD     = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_MEMWR     = 3'd5,
        ST_WRITEBACK = 3'd6,
        ST_HALT      = 3'd7
    } state_e;

    typedef struct packed {
        logic z;
        logic c;
        logic p;
    } flags_t;

    localparam logic [4:0] OP_MOV  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_ADC  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_SBB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_INC  = 5'b01001;
    localparam logic [4:0] OP_CMP  = 5'b01010;
    localparam logic [4:0] OP_LD   = 5'b01011;
    localparam logic [4:0] OP_ST   = 5'b01100;
    localparam logic [4:0] OP_JMP  = 5'b01101;
    localparam logic [4:0] OP_BRZ  = 5'b01110;
    localparam logic [4:0] OP_SHL  = 5'b10000;
    localparam logic [4:0] OP_SHR  = 5'b10001;
    localparam logic [4:0] OP_ROL  = 5'b10010;
    localparam logic [4:0] OP_ROR  = 5'b10011;
    localparam logic [4:0] OP_SAR  = 5'b10100;
    localparam logic [4:0] OP_SWP  = 5'b10101;
    localparam logic [4:0] OP_BRC  = 5'b10110;
    localparam logic [4:0] OP_BRP  = 5'b10111;
    localparam logic [4:0] OP_BRNZ = 5'b11000;
    localparam logic [4:0] OP_NEG  = 5'b11001;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    // ALU and shift ops: the only ones that may take a memory operand
    function automatic logic is_alu(input logic [4:0] op);
        return (op <= OP_CMP) || ((op >= OP_SHL) && (op <= OP_SWP)) || (op == OP_NEG);
    endfunction

    function automatic logic needs_mem_rd(input logic [4:0] op, input logic am);
        return (op == OP_LD) || (am && is_alu(op));
    endfunction

    function automatic logic writes_back(input logic [4:0] op);
        return is_alu(op) || (op == OP_LD);
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return op == OP_ST;
    endfunction

    function automatic logic is_jump(input logic [4:0] op);
        return op == OP_JMP;
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return (op == OP_BRZ) || (op == OP_BRC) || (op == OP_BRP) || (op == OP_BRNZ);
    endfunction

    function automatic logic is_ctrl(input logic [4:0] op);
        return is_jump(op) || is_branch(op);
    endfunction

    function automatic logic is_illegal(input logic [4:0] op);
        return (op == 5'b01111) || ((op >= 5'b11010) && (op <= 5'b11110));
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluation against the latched flag snapshot.
module branch_eval
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    input  flags_t     flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BRZ:  taken = flags.z;
            OP_BRC:  taken = flags.c;
            OP_BRP:  taken = flags.p;
            OP_BRNZ: taken = ~flags.z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM: sequences fetch/decode/memory/execute/writeback,
// drives stage enables and PC updates, and tracks halt/illegal/timeout faults.
module stage_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic             am,
    input  logic             mem_ready,
    input  logic             zero_in,
    input  logic             carry_in,
    input  logic             parity_in,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic             wb_en,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             halted,
    output logic             illegal_op,
    output logic             mem_fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [4:0]        opc_q, opc_d;
    flags_t            flags_q, flags_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              illegal_q, illegal_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        stage_en_q, stage_en_d;
    logic              halted_q;
    logic              pc_inc_c, pc_load_c, retire, taken;

    branch_eval u_branch_eval (
        .opcode (opc_q),
        .flags  (flags_q),
        .taken  (taken)
    );

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        flags_d   = flags_q;
        tmo_d     = '0;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        pc_inc_c  = 1'b0;
        pc_load_c = 1'b0;
        retire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                opc_d = opcode;
                if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                    retire  = 1'b1;
                end else if (needs_mem_rd(opcode, am)) begin
                    state_d = ST_MEMRD;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_MEMRD, ST_MEMWR: begin
                // mem_ready takes priority over a timeout on the same cycle
                if (mem_ready) begin
                    if (state_q == ST_MEMRD) begin
                        state_d = ST_EXECUTE;
                    end else begin
                        state_d  = ST_FETCH;
                        pc_inc_c = 1'b1;
                        retire   = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_EXECUTE: begin
                if (writes_back(opc_q)) begin
                    flags_d.z = zero_in;
                    flags_d.c = carry_in;
                    flags_d.p = parity_in;
                    state_d   = ST_WRITEBACK;
                end else if (is_store(opc_q)) begin
                    state_d = ST_MEMWR;
                end else begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                    if (is_ctrl(opc_q) && (is_jump(opc_q) || taken)) pc_load_c = 1'b1;
                    else pc_inc_c = 1'b1;
                    illegal_d = illegal_q | is_illegal(opc_q);
                end
            end
            ST_WRITEBACK: begin
                state_d  = ST_FETCH;
                pc_inc_c = 1'b1;
                retire   = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    // Stage enable bit gi belongs to state encoding gi+1 (FETCH..WRITEBACK)
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_stage_en
            assign stage_en_d[gi] = (state_d == state_e'(3'(gi + 1)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            opc_q      <= '0;
            flags_q    <= '0;
            tmo_q      <= '0;
            illegal_q  <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
            stage_en_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            flags_q    <= flags_d;
            tmo_q      <= tmo_d;
            illegal_q  <= illegal_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
            stage_en_q <= stage_en_d;
            halted_q   <= (state_d == ST_HALT);
        end
    end

    // A reset arriving on an instruction's final cycle suppresses its PC update
    assign pc_inc      = pc_inc_c & reset;
    assign pc_load     = pc_load_c & reset;
    assign fetch_en    = stage_en_q[0];
    assign decode_en   = stage_en_q[1];
    assign mem_rd_en   = stage_en_q[2];
    assign exec_en     = stage_en_q[3];
    assign mem_wr_en   = stage_en_q[4];
    assign wb_en       = stage_en_q[5];
    assign halted      = halted_q;
    assign illegal_op  = illegal_q;
    assign mem_fault   = fault_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench: an instruction-level model plans each cycle's expected
// state and outputs into a queue; a negedge monitor pops and compares.
module tb_stage_sequencer;

    localparam int T = 16;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_MEMRD = 3'd3,
                           S_EXEC = 3'd4, S_MEMWR = 3'd5, S_WB = 3'd6, S_HALT = 3'd7;

    logic clk, reset, start, am, mem_ready, zero_in, carry_in, parity_in;
    logic [4:0] opcode;
    logic fetch_en, decode_en, exec_en, mem_rd_en, mem_wr_en, wb_en;
    logic pc_inc, pc_load, halted, illegal_op, mem_fault;
    logic [2:0] state;
    logic [15:0] instr_count;

    stage_sequencer #(.MEM_TIMEOUT(T), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .am(am),
        .mem_ready(mem_ready), .zero_in(zero_in), .carry_in(carry_in), .parity_in(parity_in),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .wb_en(wb_en), .pc_inc(pc_inc), .pc_load(pc_load),
        .halted(halted), .illegal_op(illegal_op), .mem_fault(mem_fault), .state(state),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {C_ALU, C_LD, C_ST, C_JMP, C_BR, C_ILL, C_HLT} cls_e;
    typedef struct {
        logic [2:0]  st;
        bit          inc, load, halt, ill, flt;
        logic [15:0] cnt;
    } exp_t;

    cls_e cls [32];
    exp_t exp_q [$];
    exp_t e;
    int vectors = 0, miscompares = 0;

    logic [15:0] m_cnt;
    bit m_halt, m_ill, m_flt, m_z, m_c, m_p, aborted;
    int rst_in = -1, force_z = -1;

    function automatic logic [5:0] onehot(input logic [2:0] st);
        case (st)
            S_FETCH:  return 6'b000001;
            S_DECODE: return 6'b000010;
            S_MEMRD:  return 6'b000100;
            S_EXEC:   return 6'b001000;
            S_MEMWR:  return 6'b010000;
            S_WB:     return 6'b100000;
            default:  return 6'b000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("state", 32'(state), 32'(e.st));
            chk("enables", 32'({wb_en, mem_wr_en, exec_en, mem_rd_en, decode_en, fetch_en}),
                32'(onehot(e.st)));
            chk("pc_inc", 32'(pc_inc), 32'(e.inc));
            chk("pc_load", 32'(pc_load), 32'(e.load));
            chk("halted", 32'(halted), 32'(e.halt));
            chk("illegal_op", 32'(illegal_op), 32'(e.ill));
            chk("mem_fault", 32'(mem_fault), 32'(e.flt));
            chk("instr_count", 32'(instr_count), 32'(e.cnt));
        end
    end

    // One clock cycle: drive inputs (-1 = don't care, randomized), queue expectations.
    task automatic cyc(input logic [2:0] st, input bit inc, input bit load, input int strt,
                       input int op, input int a, input int rdy,
                       output bit fz, output bit fc, output bit fp);
        bit r;
        exp_t x;
        r = (rst_in == 0);
        if (rst_in >= 0) rst_in--;
        fz = (force_z >= 0) ? force_z[0] : 1'($urandom);
        fc = 1'($urandom);
        fp = 1'($urandom);
        reset     = ~r;
        start     = (strt >= 0) ? strt[0] : 1'($urandom);
        opcode    = (op >= 0) ? op[4:0] : 5'($urandom);
        am        = (a >= 0) ? a[0] : 1'($urandom);
        mem_ready = (rdy >= 0) ? rdy[0] : 1'($urandom);
        zero_in   = fz;
        carry_in  = fc;
        parity_in = fp;
        x.st = st; x.inc = inc & ~r; x.load = load & ~r;
        x.halt = m_halt; x.ill = m_ill; x.flt = m_flt; x.cnt = m_cnt;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (r) begin
            m_cnt = '0; m_halt = 0; m_ill = 0; m_flt = 0;
            m_z = 0; m_c = 0; m_p = 0; aborted = 1;
        end
    endtask

    task automatic mem_phase(input logic [2:0] st, input int w, input bit fin_inc, output bit ok);
        bit z, c, p;
        int n;
        ok = 0;
        n = (w < T) ? w : T;
        for (int i = 0; i < n; i++) begin
            cyc(st, 0, 0, -1, -1, -1, 0, z, c, p);
            if (aborted) return;
        end
        if (w >= T) begin
            m_flt = 1; m_halt = 1;
            return;
        end
        cyc(st, fin_inc, 0, -1, -1, -1, 1, z, c, p);
        if (!aborted) ok = 1;
    endtask

    task automatic run_instr(input int op, input int a, input int w);
        bit z, c, p, ok, taken;
        cyc(S_FETCH, 0, 0, -1, -1, -1, -1, z, c, p);
        if (aborted) return;
        cyc(S_DECODE, 0, 0, -1, op, a, -1, z, c, p);
        if (aborted) return;
        if (cls[op] == C_HLT) begin
            m_cnt++; m_halt = 1;
            return;
        end
        if (cls[op] == C_LD || (a != 0 && cls[op] == C_ALU)) begin
            mem_phase(S_MEMRD, w, 0, ok);
            if (!ok) return;
        end
        case (cls[op])
            C_ALU, C_LD: begin
                cyc(S_EXEC, 0, 0, -1, -1, -1, -1, z, c, p);
                if (aborted) return;
                m_z = z; m_c = c; m_p = p;
                cyc(S_WB, 1, 0, -1, -1, -1, -1, z, c, p);
                if (aborted) return;
                m_cnt++;
            end
            C_ST: begin
                cyc(S_EXEC, 0, 0, -1, -1, -1, -1, z, c, p);
                if (aborted) return;
                mem_phase(S_MEMWR, w, 1, ok);
                if (ok) m_cnt++;
            end
            C_JMP: begin
                cyc(S_EXEC, 0, 1, -1, -1, -1, -1, z, c, p);
                if (aborted) return;
                m_cnt++;
            end
            C_BR: begin
                case (op)
                    14:      taken = m_z;
                    22:      taken = m_c;
                    23:      taken = m_p;
                    default: taken = !m_z;
                endcase
                cyc(S_EXEC, !taken, taken, -1, -1, -1, -1, z, c, p);
                if (aborted) return;
                m_cnt++;
            end
            default: begin
                cyc(S_EXEC, 1, 0, -1, -1, -1, -1, z, c, p);
                if (aborted) return;
                m_ill = 1; m_cnt++;
            end
        endcase
    endtask

    task automatic idle_start(input int n);
        bit z, c, p;
        for (int i = 0; i < n; i++) cyc(S_IDLE, 0, 0, 0, -1, -1, -1, z, c, p);
        cyc(S_IDLE, 0, 0, 1, -1, -1, -1, z, c, p);
    endtask

    // After halt or reset abort: hold HALT with start=1, reset, restart from IDLE.
    task automatic do_instr(input int op, input int a, input int w);
        bit z, c, p;
        run_instr(op, a, w);
        if (m_halt && !aborted) begin
            rst_in = -1;
            for (int i = 0; i < 3; i++) cyc(S_HALT, 0, 0, 1, -1, -1, -1, z, c, p);
            rst_in = 0;
            cyc(S_HALT, 0, 0, 1, -1, -1, -1, z, c, p);
        end
        if (aborted) begin
            aborted = 0;
            rst_in = -1;
            idle_start(1);
        end
        rst_in = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, a, w;
        for (int i = 0; i < 32; i++) cls[i] = C_ILL;
        for (int i = 0; i <= 10; i++) cls[i] = C_ALU;
        for (int i = 16; i <= 21; i++) cls[i] = C_ALU;
        cls[25] = C_ALU; cls[11] = C_LD; cls[12] = C_ST; cls[13] = C_JMP;
        cls[14] = C_BR; cls[22] = C_BR; cls[23] = C_BR; cls[24] = C_BR; cls[31] = C_HLT;
        m_cnt = '0; m_halt = 0; m_ill = 0; m_flt = 0; m_z = 0; m_c = 0; m_p = 0; aborted = 0;
        reset = 0; start = 0; opcode = '0; am = 0; mem_ready = 0;
        zero_in = 0; carry_in = 0; parity_in = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        idle_start(2);
        do_instr(1, 0, 0);                   // ADD register mode
        do_instr(1, 1, 3);                   // ADD memory operand, 3 wait cycles
        force_z = 1;
        do_instr(3, 0, 0);                   // SUB sets Z
        force_z = -1;
        do_instr(14, 0, 0);                  // BRZ taken
        do_instr(24, 0, 0);                  // BRNZ not taken
        rst_in = 4;
        do_instr(1, 1, 10);                  // reset during MEMRD wait
        do_instr(12, 0, 15);                 // store: ready on the last allowed cycle
        do_instr(11, 0, 0);
        do_instr(13, 0, 0);
        do_instr(15, 0, 0);
        for (int k = 0; k < 200; k++) begin
            op = $urandom_range(0, 31);
            a  = $urandom_range(0, 1);
            w  = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
            if ($urandom_range(0, 19) == 0) rst_in = $urandom_range(0, 8);
            do_instr(op, a, w);
        end
        do_instr(12, 0, 16);                 // store timeout -> mem_fault, halt
        do_instr(26, 0, 0);                  // illegal opcode
        do_instr(31, 0, 0);                  // halt, start held high
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle control FSM for the 8-bit core. It sequences fetch, decode, optional memory read, execute, memory write and writeback for each instruction, and drives the stage enables, including `enable` of the execute stage.
It also latches ALU flags for branch decisions, updates the PC, and handles halt, illegal-opcode and memory-timeout conditions.
It sits between the instruction/data memory handshakes and the fetch/decode/execute/register-file stages.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEMRD/MEMWR waiting for mem_ready before a fault
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
start  in  1  leave IDLE and begin fetching
opcode  in  5  opcode from decode stage, valid in DECODE
am  in  1  addressing mode from decode stage (1 = memory operand), valid in DECODE
mem_ready  in  1  data-memory handshake complete
zero_in, carry_in, parity_in  in  1 each  flags from execute stage, valid in EXECUTE
fetch_en, decode_en, exec_en, mem_rd_en, mem_wr_en, wb_en  out  1 each  stage enables
pc_inc  out  1  PC += 1 this cycle
pc_load  out  1  PC <= branch/jump target this cycle
halted  out  1  core halted
illegal_op  out  1  sticky illegal-opcode flag
mem_fault  out  1  sticky memory-timeout flag
state  out  3  current FSM state (debug)
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE.
  - All enables, pc_inc, pc_load, halted, illegal_op and mem_fault are 0.
  - instr_count=0; latched opcode/am/flags=0; timeout counter=0.
  - Reset mid-instruction aborts the instruction with no pc_inc/pc_load.
- States (encoding 0..7): IDLE, FETCH, DECODE, MEMRD, EXECUTE, MEMWR, WRITEBACK, HALT.
- Stage enables are Moore outputs, one-hot with state:
  - fetch_en=FETCH, decode_en=DECODE, mem_rd_en=MEMRD, exec_en=EXECUTE, mem_wr_en=MEMWR, wb_en=WRITEBACK.
- IDLE: to FETCH when start=1; otherwise stay.
- FETCH: to DECODE after 1 cycle.
- DECODE: latch opcode and am.
  - 11111 -> HALT.
  - 01011 (load), or any ALU/shift op with am=1 -> MEMRD.
  - Otherwise -> EXECUTE.
- MEMRD / MEMWR: wait for mem_ready.
  - Timeout counter clears on state entry and increments each waiting cycle.
  - mem_ready=1 -> MEMRD goes to EXECUTE; MEMWR ends the instruction.
  - Counter reaching MEM_TIMEOUT-1 without mem_ready -> set mem_fault, go to HALT, no PC update.
  - If mem_ready arrives on that same cycle, mem_ready wins.
- EXECUTE:
  - Ops 00000-01010, 01011, 10000-10101, 11001 -> WRITEBACK.
  - 01100 (store) -> MEMWR.
  - 01101 (jump) -> pc_load=1, then FETCH.
  - Branches: 01110 taken if Z, 10110 if C, 10111 if P, 11000 if !Z.
    - Taken -> pc_load=1; not taken -> pc_inc=1; then FETCH.
  - Undefined opcodes (01111, 11010-11110) -> set illegal_op, treat as NOP: pc_inc=1, then FETCH.
- Flag snapshot:
  - Latch Z/C/P from zero_in/carry_in/parity_in at the EXECUTE cycle of every op that goes to WRITEBACK.
  - Branch, jump, store and NOP ops do not modify the snapshot.
  - Branches evaluate the snapshot, never the live inputs.
- WRITEBACK: pc_inc=1, then FETCH.
- Instruction end:
  - An instruction ends on its final cycle: WRITEBACK; MEMWR with mem_ready; EXECUTE for jump/branch/NOP.
  - pc_inc and pc_load are combinational, single-cycle and mutually exclusive in that final cycle.
  - instr_count increments in the same cycle; it wraps at 2^CNT_W-1 -> 0.
- HALT: halted=1; absorbing until reset; start ignored. Halt (11111) increments instr_count on the DECODE->HALT transition.
- Latencies (cycles per instruction): ALU reg mode 4; ALU am=1 / load 5 + mem wait; store 4 + mem wait; jump/branch/NOP 3.

Decomposition:
- Package `cpu_pkg`: 5-bit opcode constants (OP_MOV..OP_CMP, OP_JMP, OP_BRZ/BRC/BRP/BRNZ, OP_HLT) and 3-bit state encodings. Shared with the execute stage.
- Sub-module `branch_eval` (combinational): latched opcode + flag snapshot -> taken.
- Opcode classification (needs_mem_rd, is_store, is_ctrl, is_illegal) as package functions.

Test Plan:
- reset=0 during MEMRD wait, then release -> state=IDLE, all outputs 0, instr_count=0, no pc pulse.
- start; opcode=00001 am=0 -> states FETCH, DECODE, EXECUTE, WRITEBACK; pc_inc in cycle 4; instr_count=1.
- opcode=00001 am=1, mem_ready after 3 wait cycles -> MEMRD held 4 cycles, then EXECUTE, WRITEBACK; total 8 cycles.
- SUB with zero_in=1 at EXECUTE, then opcode=01110 -> pc_load=1, pc_inc=0; then opcode=11000 -> pc_inc=1.
- opcode=01100, mem_ready held 0 -> mem_fault=1 after MEM_TIMEOUT=16 wait cycles, halted=1, no pc pulse.
- opcode=11010 -> illegal_op=1 and pc_inc=1; then opcode=11111 -> halted=1, stays HALT despite start=1.
